// File: rtl/code_decoder_dispatch.sv
// Buffered 3-to-8 one-hot decoder: encoded indices queue in a small FIFO and are
// presented one at a time as a held one-hot line until acked. DEC_OVF_EN adds a sticky ovf flag.
module code_decoder_dispatch #(
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [2:0]    code_in,
    input  logic          code_valid,
    output logic          code_ready,
    output logic [7:0]    y,
    output logic          y_valid,
    input  logic          ack,
    output logic [CW-1:0] count
`ifdef DEC_OVF_EN
    ,
    output logic          ovf
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic IDLE   = 1'b0;
    localparam logic ACTIVE = 1'b1;

    logic [2:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;
    logic          state_reg;
    logic [7:0]    y_reg;
    logic          y_valid_reg;
    logic [2:0]    head_code;
    logic [7:0]    head_onehot;
    logic          push;
    logic          pop;

    assign code_ready = (count_reg != CW'(DEPTH));
    assign push       = code_valid && code_ready;
    // Pop whenever a line can be (re)loaded: from IDLE unconditionally, from ACTIVE only on ack.
    assign pop        = (count_reg != '0) && ((state_reg == IDLE) || ack);
    assign count_next = count_reg + CW'(push) - CW'(pop);
    assign head_code  = mem[rd_ptr_reg];

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_dec
            assign head_onehot[gi] = (head_code == 3'(gi));
        end
    endgenerate

    // Storage has no reset so it can map onto plain distributed/block memory.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr_reg] <= code_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
            state_reg   <= IDLE;
            y_reg       <= '0;
            y_valid_reg <= 1'b0;
        end else begin
            count_reg <= count_next;
            if (push)
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop) begin
                rd_ptr_reg  <= rd_ptr_reg + AW'(1);
                y_reg       <= head_onehot;
                y_valid_reg <= 1'b1;
                state_reg   <= ACTIVE;
            end else if (state_reg == ACTIVE && ack) begin
                y_reg       <= '0;
                y_valid_reg <= 1'b0;
                state_reg   <= IDLE;
            end
        end
    end

    assign y       = y_reg;
    assign y_valid = y_valid_reg;
    assign count   = count_reg;

`ifdef DEC_OVF_EN
    logic ovf_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ovf_reg <= 1'b0;
        else if (code_valid && !code_ready)
            ovf_reg <= 1'b1;
    end

    assign ovf = ovf_reg;
`endif

endmodule

// File: tb/tb_code_decoder_dispatch.sv
// Directed bench for code_decoder_dispatch (DEPTH=4); ovf checks only when DEC_OVF_EN is defined.
module tb_code_decoder_dispatch;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] code_in;
    logic       code_valid;
    logic       code_ready;
    logic [7:0] y;
    logic       y_valid;
    logic       ack;
    logic [2:0] count;
`ifdef DEC_OVF_EN
    logic       ovf;
`endif

    int checks = 0;
    int errors = 0;

    code_decoder_dispatch #(.DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .code_in    (code_in),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .y          (y),
        .y_valid    (y_valid),
        .ack        (ack),
        .count      (count)
`ifdef DEC_OVF_EN
        ,
        .ovf        (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [7:0] ey, input logic ev, input logic [2:0] ec);
        check({tag, ".y"}, 32'(y), 32'(ey));
        check({tag, ".y_valid"}, 32'(y_valid), 32'(ev));
        check({tag, ".count"}, 32'(count), 32'(ec));
    endtask

    logic [2:0] codes [11];

    initial begin
        codes = '{3'd3, 3'd6, 3'd1, 3'd4, 3'd7, 3'd0, 3'd5, 3'd2, 3'd3, 3'd6, 3'd1};
        rst = 1'b1; code_in = '0; code_valid = 1'b0; ack = 1'b0;
        #1;
        check("rst.code_ready", 32'(code_ready), 32'd1);
        check_out("rst", 8'h00, 1'b0, 3'd0);
        step(); step();
        rst = 1'b0;

        // Single code
        code_in = 3'd5; code_valid = 1'b1;
        step();
        code_valid = 1'b0;
        check_out("single.e1", 8'h00, 1'b0, 3'd1);
        step();
        check_out("single.e2", 8'h20, 1'b1, 3'd0);
        ack = 1'b1;
        step();
        ack = 1'b0;
        check_out("single.ack", 8'h00, 1'b0, 3'd0);

        // Back-to-back with ack held
        ack = 1'b1;
        code_in = 3'd0; code_valid = 1'b1;
        step();
        check_out("b2b.a", 8'h00, 1'b0, 3'd1);
        code_in = 3'd7;
        step();
        check_out("b2b.b", 8'h01, 1'b1, 3'd1);
        code_in = 3'd2;
        step();
        check_out("b2b.c", 8'h80, 1'b1, 3'd1);
        code_valid = 1'b0;
        step();
        check_out("b2b.d", 8'h04, 1'b1, 3'd0);
        step();
        check_out("b2b.e", 8'h00, 1'b0, 3'd0);
        ack = 1'b0;

        // Fill to full, hold off the sixth code
        code_valid = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            code_in = 3'(i);
            step();
        end
        check_out("full", 8'h02, 1'b1, 3'd4);
        check("full.code_ready", 32'(code_ready), 32'd0);
        code_in = 3'd6;
        step();
        check_out("full.held", 8'h02, 1'b1, 3'd4);
`ifdef DEC_OVF_EN
        check("full.ovf", 32'(ovf), 32'd1);
`endif
        ack = 1'b1;
        step();
        check_out("full.pop_no_push", 8'h04, 1'b1, 3'd3);
        check("full.ready_again", 32'(code_ready), 32'd1);
        ack = 1'b0;
        step();
        code_valid = 1'b0;
        check_out("full.sixth_in", 8'h04, 1'b1, 3'd4);
        ack = 1'b1;
        step(); check_out("drain.3", 8'h08, 1'b1, 3'd3);
        step(); check_out("drain.4", 8'h10, 1'b1, 3'd2);
        step(); check_out("drain.5", 8'h20, 1'b1, 3'd1);
        step(); check_out("drain.6", 8'h40, 1'b1, 3'd0);
        step(); check_out("drain.idle", 8'h00, 1'b0, 3'd0);
`ifdef DEC_OVF_EN
        check("drain.ovf_sticky", 32'(ovf), 32'd1);
`endif
        ack = 1'b0;

        // Simultaneous push/pop at count=2, pointers wrap
        code_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            code_in = codes[i];
            step();
        end
        check_out("sim.pre", 8'(1 << codes[0]), 1'b1, 3'd2);
        ack = 1'b1;
        for (int k = 0; k < 8; k++) begin
            code_in = codes[3 + k];
            step();
            check_out($sformatf("sim.k%0d", k), 8'(1 << codes[1 + k]), 1'b1, 3'd2);
        end
        code_valid = 1'b0;
        step(); check_out("sim.tail9", 8'(1 << codes[9]), 1'b1, 3'd1);
        step(); check_out("sim.tail10", 8'(1 << codes[10]), 1'b1, 3'd0);
        step(); check_out("sim.idle", 8'h00, 1'b0, 3'd0);

        // Spurious ack while idle and empty
        step();
        check_out("spurious", 8'h00, 1'b0, 3'd0);
        ack = 1'b0;

        // Asynchronous reset mid-cycle with y_valid=1, count=3
        code_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            code_in = 3'(i + 4);
            step();
        end
        code_valid = 1'b0;
        check_out("arst.pre", 8'h10, 1'b1, 3'd3);
        #3;
        rst = 1'b1;
        #1;
        check_out("arst", 8'h00, 1'b0, 3'd0);
        check("arst.code_ready", 32'(code_ready), 32'd1);
`ifdef DEC_OVF_EN
        check("arst.ovf", 32'(ovf), 32'd0);
`endif
        step();
        rst = 1'b0;

        // Normal operation after reset
        code_in = 3'd1; code_valid = 1'b1;
        step();
        code_valid = 1'b0;
        step();
        check_out("post", 8'h02, 1'b1, 3'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
